// File: rtl/led_seq_pkg.sv
// Shared types, encodings and pattern helpers for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_PING = 2'd2,
        MODE_FILL = 2'd3
    } mode_e;

    localparam logic [7:0] PAT_INIT_LEFT  = 8'h01;
    localparam logic [7:0] PAT_INIT_RIGHT = 8'h80;
    localparam logic [7:0] PAT_INIT_FILL  = 8'h00;
    localparam logic [7:0] PAT_OFF        = 8'h00;
    localparam logic [7:0] PAT_FULL       = 8'hFF;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [7:0] init_pattern(input mode_e m);
        logic [7:0] p;
        case (m)
            MODE_ROL:  p = PAT_INIT_LEFT;
            MODE_ROR:  p = PAT_INIT_RIGHT;
            MODE_PING: p = PAT_INIT_LEFT;
            MODE_FILL: p = PAT_INIT_FILL;
            default:   p = PAT_OFF;
        endcase
        return p;
    endfunction

    // Returns {next_dir, next_led}; ping-pong turns around at either end without dwelling.
    function automatic logic [8:0] advance_pattern(input mode_e m, input logic [7:0] led,
                                                   input logic dir);
        logic [7:0] n_led;
        logic       n_dir;
        n_led = led;
        n_dir = dir;
        case (m)
            MODE_ROL: n_led = {led[6:0], led[7]};
            MODE_ROR: n_led = {led[0], led[7:1]};
            MODE_PING: begin
                if (dir == DIR_LEFT) begin
                    if (led == 8'h80) begin
                        n_led = 8'h40;
                        n_dir = DIR_RIGHT;
                    end else begin
                        n_led = {led[6:0], 1'b0};
                    end
                end else begin
                    if (led == 8'h01) begin
                        n_led = 8'h02;
                        n_dir = DIR_LEFT;
                    end else begin
                        n_led = {1'b0, led[7:1]};
                    end
                end
            end
            MODE_FILL: n_led = (led == PAT_FULL) ? PAT_OFF : {led[6:0], 1'b1};
            default:   n_led = PAT_OFF;
        endcase
        return {n_dir, n_led};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..P-1 with P = DIV_BASE >> speed, strobing on the last count.
module led_tick_gen #(
    parameter int DIV_BASE = 25_000_000
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    localparam int            CW   = $clog2(DIV_BASE + 1);
    localparam logic [CW-1:0] BASE = CW'(DIV_BASE);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_period;
    logic [CW-1:0] w_period;

    // Speed is only looked at on count 0, so a period never changes length mid-way.
    assign w_period = (r_cnt == '0) ? (BASE >> i_speed) : r_period;
    assign o_tick   = i_enable && (r_cnt == (w_period - CW'(1)));

    // Count and period registers; hold while disabled so a pause resumes mid-period.
    always_ff @(posedge clk_50mhz) begin
        if (rst || i_clear) begin
            r_cnt    <= '0;
            r_period <= BASE;
        end else if (i_enable) begin
            r_period <= w_period;
            r_cnt    <= o_tick ? '0 : (r_cnt + CW'(1));
        end else begin
            r_cnt    <= r_cnt;
            r_period <= r_period;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: IDLE/RUN/PAUSE control around a prescaler, all outputs registered.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DIV_BASE = 25_000_000
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic       tick,
    output logic       busy
);

    state_e     r_state, w_state_nxt;
    mode_e      r_mode, w_mode_nxt;
    logic       r_dir, w_dir_nxt;
    logic [7:0] r_led, w_led_nxt;
    logic       r_start_d;
    logic       r_tick;
    logic       r_busy;
    logic       w_start_edge;
    logic       w_tick_en;
    logic       w_clear;
    logic       w_step;
    logic [8:0] w_adv;

    // Stop takes effect in the cycle it is seen, so the prescaler is frozen in that cycle too.
    assign w_start_edge = start & ~r_start_d;
    assign w_tick_en    = (r_state == ST_RUN) & ~stop;
    assign w_clear      = (r_state == ST_IDLE);
    assign w_adv        = advance_pattern(r_mode, r_led, r_dir);

    led_tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_enable  (w_tick_en),
        .i_speed   (speed),
        .o_tick    (w_step)
    );

    // Next-state and next-pattern decode.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_led_nxt   = r_led;
        case (r_state)
            ST_IDLE: begin
                if (!stop && w_start_edge) begin
                    w_state_nxt = ST_RUN;
                    w_mode_nxt  = mode_e'(mode);
                    w_dir_nxt   = DIR_LEFT;
                    w_led_nxt   = init_pattern(mode_e'(mode));
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_step) begin
                    w_led_nxt = w_adv[7:0];
                    w_dir_nxt = w_adv[8];
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_led_nxt   = PAT_OFF;
                end else if (w_start_edge) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = PAT_OFF;
            end
        endcase
    end

    // State and output registers; start history resets high so a held start needs a fresh edge.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_ROL;
            r_dir     <= DIR_LEFT;
            r_led     <= PAT_OFF;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_start_d <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_dir     <= w_dir_nxt;
            r_led     <= w_led_nxt;
            r_tick    <= w_step;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_start_d <= start;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;
    assign busy = r_busy;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with DIV_BASE=8: directed scenarios plus random traffic vs a step-count model.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] led;
    logic       tick;
    logic       busy;

    int n_chk;
    int n_fail;

    // Reference model: state, ticks since start, position within the current period.
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    int         m_st;
    int         m_k;
    int         m_cnt;
    int         m_per;
    int         m_mode;
    logic       m_start_prev;
    logic [7:0] m_led;
    logic       m_tick;

    led_seq_ctrl #(.DIV_BASE(8)) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .speed     (speed),
        .led       (led),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern after k steps, straight from the pattern definitions.
    function automatic logic [7:0] pat(input int md, input int k);
        int p;
        case (md)
            0: return 8'(1 << (k % 8));
            1: return 8'(128 >> (k % 8));
            2: begin
                p = k % 14;
                if (p > 7) p = 14 - p;
                return 8'(1 << p);
            end
            default: return 8'((1 << (k % 9)) - 1);
        endcase
    endfunction

    task automatic clk_step();
        logic e_s;
        @(posedge clk);
        e_s = start && !m_start_prev;
        if (rst) begin
            m_st = M_IDLE; m_led = 8'h00; m_tick = 1'b0; m_k = 0; m_cnt = 0;
            m_per = 8; m_mode = 0; m_start_prev = 1'b1;
        end else begin
            m_start_prev = start;
            m_tick = 1'b0;
            case (m_st)
                M_IDLE: if (!stop && e_s) begin
                    m_st = M_RUN; m_mode = int'(mode); m_k = 0; m_cnt = 0;
                    m_led = pat(m_mode, 0);
                end
                M_RUN: if (stop) m_st = M_PAUSE;
                else begin
                    if (m_cnt == 0) m_per = 8 >> speed;
                    if (m_cnt == m_per - 1) begin
                        m_k++; m_led = pat(m_mode, m_k); m_tick = 1'b1; m_cnt = 0;
                    end else m_cnt++;
                end
                default: if (stop) begin
                    m_st = M_IDLE; m_led = 8'h00; m_cnt = 0;
                end else if (e_s) m_st = M_RUN;
            endcase
        end
        #1;
    endtask

    task automatic start_run(input logic [1:0] md);
        mode = md; start = 1'b1; clk_step(); start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1; clk_step(); stop = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin clk_step(); n++; end while (tick !== 1'b1 && n < 40);
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 2'd0; speed = 2'd0;
        repeat (3) clk_step();
        n_chk++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h exp 00", led); end
        n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0; seen = 1'b0;
        repeat (20) begin clk_step(); if (busy !== 1'b0) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL held_start_after_reset busy seen %b exp 0", seen); end
        start = 1'b0; clk_step();
    endtask

    task automatic test_rotate_left();
        int n; logic [7:0] e;
        speed = 2'd0; start_run(2'd0);
        n_chk++; if (led !== 8'h01) begin n_fail++; $display("FAIL rol_entry_led got %h exp 01", led); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rol_entry_busy got %b exp 1", busy); end
        for (int i = 1; i <= 9; i++) begin
            wait_tick(n);
            e = 8'h01; e = e << (i % 8);
            n_chk++; if (n != 8) begin n_fail++; $display("FAIL rol_period tick %0d got %0d exp 8", i, n); end
            n_chk++; if (led !== e) begin n_fail++; $display("FAIL rol_led tick %0d got %h exp %h", i, led, e); end
            n_chk++; if (led !== m_led) begin n_fail++; $display("FAIL rol_model tick %0d got %h exp %h", i, led, m_led); end
        end
        stop_pulse(); stop_pulse();
        n_chk++; if (busy !== 1'b0 || led !== 8'h00) begin n_fail++; $display("FAIL rol_to_idle got busy %b led %h exp 0 00", busy, led); end
    endtask

    task automatic test_pingpong();
        int n, p, c80, c01; logic [7:0] e;
        c80 = 0; c01 = 0;
        start_run(2'd2);
        n_chk++; if (led !== 8'h01) begin n_fail++; $display("FAIL ping_entry_led got %h exp 01", led); end
        for (int i = 1; i <= 16; i++) begin
            wait_tick(n);
            p = i % 14; if (p > 7) p = 14 - p;
            e = 8'h01; e = e << p;
            n_chk++; if (led !== e) begin n_fail++; $display("FAIL ping_led tick %0d got %h exp %h", i, led, e); end
            if (led === 8'h80) c80++;
            if (led === 8'h01) c01++;
        end
        n_chk++; if (c80 != 1) begin n_fail++; $display("FAIL ping_80_count got %0d exp 1", c80); end
        n_chk++; if (c01 != 1) begin n_fail++; $display("FAIL ping_01_count got %0d exp 1", c01); end
        stop_pulse(); stop_pulse();
    endtask

    task automatic test_fill();
        int n; logic [7:0] fe [11];
        fe = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
        start_run(2'd3);
        n_chk++; if (led !== fe[0]) begin n_fail++; $display("FAIL fill_entry_led got %h exp %h", led, fe[0]); end
        for (int i = 1; i <= 10; i++) begin
            wait_tick(n);
            n_chk++; if (led !== fe[i]) begin n_fail++; $display("FAIL fill_led tick %0d got %h exp %h", i, led, fe[i]); end
        end
        stop_pulse(); stop_pulse();
    endtask

    task automatic test_pause_resume();
        int n; logic bad; logic [7:0] frozen;
        speed = 2'd0; start_run(2'd0);
        repeat (5) clk_step();
        stop_pulse();
        frozen = led; bad = 1'b0;
        n_chk++; if (led !== 8'h01 || busy !== 1'b1) begin n_fail++; $display("FAIL pause_enter got led %h busy %b exp 01 1", led, busy); end
        repeat (20) begin clk_step(); if (led !== frozen || tick !== 1'b0) bad = 1'b1; end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL pause_frozen got changed %b exp 0", bad); end
        start = 1'b1; clk_step(); start = 1'b0;
        wait_tick(n);
        n_chk++; if (n != 3) begin n_fail++; $display("FAIL resume_latency got %0d exp 3", n); end
        n_chk++; if (led !== 8'h02) begin n_fail++; $display("FAIL resume_led got %h exp 02", led); end
        stop_pulse();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pause2_busy got %b exp 1", busy); end
        stop_pulse();
        n_chk++; if (led !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL pause_to_idle got led %h busy %b exp 00 0", led, busy); end
    endtask

    task automatic test_start_stop_same();
        logic bad; logic [7:0] frozen;
        start = 1'b1; stop = 1'b1; clk_step(); start = 1'b0; stop = 1'b0;
        repeat (5) clk_step();
        n_chk++; if (busy !== 1'b0 || led !== 8'h00) begin n_fail++; $display("FAIL both_idle got busy %b led %h exp 0 00", busy, led); end
        start_run(2'd1);
        n_chk++; if (led !== 8'h80) begin n_fail++; $display("FAIL ror_entry_led got %h exp 80", led); end
        repeat (3) clk_step();
        start = 1'b1; stop = 1'b1; clk_step(); start = 1'b0; stop = 1'b0;
        frozen = led; bad = 1'b0;
        repeat (12) begin clk_step(); if (tick !== 1'b0 || led !== frozen || busy !== 1'b1) bad = 1'b1; end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL both_run_pause got not_paused %b exp 0", bad); end
        stop_pulse();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL both_to_idle got %b exp 0", busy); end
    endtask

    task automatic test_speed_and_reset();
        int n;
        speed = 2'd0; start_run(2'd0);
        repeat (3) clk_step();
        speed = 2'd2;
        wait_tick(n);
        n_chk++; if (n != 5) begin n_fail++; $display("FAIL speed_cur_period got %0d exp 5 after change", n); end
        wait_tick(n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL speed_new_period1 got %0d exp 2", n); end
        wait_tick(n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL speed_new_period2 got %0d exp 2", n); end
        n_chk++; if (led !== 8'h08) begin n_fail++; $display("FAIL speed_led got %h exp 08", led); end
        clk_step();
        rst = 1'b1; clk_step();
        n_chk++; if (led !== 8'h00 || tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_run got led %h tick %b busy %b exp 00 0 0", led, tick, busy); end
        rst = 1'b0; clk_step();
        n_chk++; if (tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after got tick %b busy %b exp 0 0", tick, busy); end
        speed = 2'd0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            stop = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
            clk_step();
            n_chk++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led cyc %0d got %h exp %h", c, led, m_led); end
            n_chk++; if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d got %b exp %b", c, tick, m_tick); end
            n_chk++; if (busy !== (m_st != M_IDLE)) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, busy, (m_st != M_IDLE)); end
        end
        rst = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; speed = 2'd0;
        m_st = M_IDLE; m_k = 0; m_cnt = 0; m_per = 8; m_mode = 0;
        m_start_prev = 1'b1; m_led = 8'h00; m_tick = 1'b0;
        test_reset();
        test_rotate_left();
        test_pingpong();
        test_fill();
        test_pause_resume();
        test_start_stop_same();
        test_speed_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
